// File: rtl/aurora_mem_pkg.sv
// Shared types and constants for the aurora MEM stage: op/size encodings,
// FSM states and the access-size helper.
package aurora_mem_pkg;

    localparam int DATA_W  = 64;
    localparam int MEM_AW  = 8;
    localparam int BYTE_AW = MEM_AW + 3;
    localparam int RD_W    = 5;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 64-bit memory word and the register view:
// load extract/extend, store merge and alignment check.
module mem_lane_align import aurora_mem_pkg::*; (
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        offset,
    input  size_e             size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] load_result,
    output logic [DATA_W-1:0] merged,
    output logic              misalign
);

    logic [5:0]        shamt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic signed [31:0] lane_w;

    assign shamt   = {offset, 3'b000};
    assign shifted = mem_word >> shamt;
    assign lane_b  = shifted[7:0];
    assign lane_h  = shifted[15:0];
    assign lane_w  = shifted[31:0];

    always_comb begin
        mask = '1;
        case (size)
            SZ_B:    mask = 64'h0000_0000_0000_00FF;
            SZ_H:    mask = 64'h0000_0000_0000_FFFF;
            SZ_W:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = '1;
        endcase
    end

    // Signed lanes widen through a size cast so the sign bit replicates.
    always_comb begin
        load_result = shifted & mask;
        if (is_signed) begin
            case (size)
                SZ_B:    load_result = DATA_W'(lane_b);
                SZ_H:    load_result = DATA_W'(lane_h);
                SZ_W:    load_result = DATA_W'(lane_w);
                default: load_result = shifted;
            endcase
        end
    end

    assign merged   = (mem_word & ~(mask << shamt)) | ((wdata & mask) << shamt);
    assign misalign = (offset & 3'(size_bytes(size) - 4'd1)) != 3'd0;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage of the aurora core: drives the 256 x 64 data memory,
// performs loads, full stores and read-modify-write partial stores.
module mem_access_stage #(
    parameter int DATA_W  = 64,
    parameter int MEM_AW  = 8,
    parameter int BYTE_AW = 11,
    parameter int RD_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [1:0]         in_size,
    input  logic               in_signed,
    input  logic [BYTE_AW-1:0] in_addr,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [RD_W-1:0]    in_rd,
    input  logic               in_wb_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [RD_W-1:0]    out_rd,
    output logic               out_wb_en,
    output logic               out_misalign,
    output logic [MEM_AW-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_data_in,
    output logic               mem_write_en,
    output logic               mem_read_en,
    input  logic [DATA_W-1:0]  mem_data_out
);

    import aurora_mem_pkg::*;

    state_e             state, state_nxt;
    op_e                op;
    size_e              size;
    logic               accept;
    logic               is_load, is_store, is_full;
    logic               lane_misalign, mis_acc, rmw_start;
    logic [DATA_W-1:0]  load_result, merged;
    logic [DATA_W-1:0]  merged_p0;
    logic [MEM_AW-1:0]  waddr_p0;
    logic [RD_W-1:0]    rd_p0;

    assign op        = op_e'(in_op);
    assign size      = size_e'(in_size);
    assign is_load   = (op == OP_LOAD);
    assign is_store  = (op == OP_STORE);
    assign is_full   = (size == SZ_D);
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mis_acc   = (is_load || is_store) && lane_misalign;
    assign rmw_start = accept && is_store && !is_full && !mis_acc;

    mem_lane_align u_lane (
        .mem_word    (mem_data_out),
        .wdata       (in_wdata),
        .offset      (in_addr[2:0]),
        .size        (size),
        .is_signed   (in_signed),
        .load_result (load_result),
        .merged      (merged),
        .misalign    (lane_misalign)
    );

    always_comb begin
        state_nxt    = state;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_address  = in_addr[BYTE_AW-1:3];
        mem_data_in  = in_wdata;
        case (state)
            ST_IDLE: begin
                if (accept && !mis_acc) begin
                    if (is_load) begin
                        mem_read_en = 1'b1;
                    end else if (is_store && is_full) begin
                        mem_write_en = 1'b1;
                    end else if (is_store) begin
                        mem_read_en = 1'b1;
                        state_nxt   = ST_RMW_WRITE;
                    end
                end
            end
            ST_RMW_WRITE: begin
                mem_address  = waddr_p0;
                mem_data_in  = merged_p0;
                mem_write_en = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Holding reset must never let a half-finished RMW reach memory.
        if (!rst_n) begin
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            mem_address  = '0;
            mem_data_in  = '0;
        end
    end

    // Stage p0: merged word and writeback tag held across the RMW write cycle
    always_ff @(posedge clk) begin
        if (rmw_start) begin
            merged_p0 <= merged;
            waddr_p0  <= in_addr[BYTE_AW-1:3];
            rd_p0     <= in_rd;
        end
    end

    // Stage p1: result register towards writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_wb_en    <= 1'b0;
            out_misalign <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_RMW_WRITE) begin
                out_valid    <= 1'b1;
                out_data     <= '0;
                out_rd       <= rd_p0;
                out_wb_en    <= 1'b0;
                out_misalign <= 1'b0;
            end else if (rmw_start) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_rd       <= in_rd;
                out_misalign <= mis_acc;
                if (mis_acc || is_store) begin
                    out_data  <= '0;
                    out_wb_en <= 1'b0;
                end else if (is_load) begin
                    out_data  <= load_result;
                    out_wb_en <= in_wb_en;
                end else begin
                    out_data  <= in_alu_result;
                    out_wb_en <= in_wb_en;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural 256 x 64 memory.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [1:0]  in_size;
    logic        in_signed;
    logic [10:0] in_addr;
    logic [63:0] in_alu_result;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_misalign;
    logic [7:0]  mem_address;
    logic [63:0] mem_data_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [63:0] mem_data_out;

    logic [63:0] mem [256] = '{default: '0};
    int          wr_count = 0;
    int          errors = 0;
    int          checks = 0;
    int          wc0;
    logic        acc_rdy, acc_rd, acc_wr;

    localparam logic [1:0] PASS = 2'd0, LOAD = 2'd1, STORE = 2'd2, RSVD = 2'd3;
    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, D = 2'd3;

    mem_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_size       (in_size),
        .in_signed     (in_signed),
        .in_addr       (in_addr),
        .in_alu_result (in_alu_result),
        .in_wdata      (in_wdata),
        .in_rd         (in_rd),
        .in_wb_en      (in_wb_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_wb_en     (out_wb_en),
        .out_misalign  (out_misalign),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
        .mem_data_out  (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_address] <= mem_data_in;
            wr_count         <= wr_count + 1;
        end
    end

    assign mem_data_out = mem_read_en ? mem[mem_address] : 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                          input logic [10:0] addr, input logic [63:0] alu,
                          input logic [63:0] wd, input logic [4:0] rd, input logic wb);
        in_valid      = 1'b1;
        in_op         = op;
        in_size       = sz;
        in_signed     = sgn;
        in_addr       = addr;
        in_alu_result = alu;
        in_wdata      = wd;
        in_rd         = rd;
        in_wb_en      = wb;
    endtask

    // Presents one transfer for a single cycle, recording the accept-cycle controls.
    task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                         input logic [10:0] addr, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [4:0] rd, input logic wb);
        @(negedge clk);
        set_in(op, sz, sgn, addr, alu, wd, rd, wb);
        #1;
        acc_rdy = in_ready;
        acc_rd  = mem_read_en;
        acc_wr  = mem_write_en;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_in(LOAD, D, 1'b0, 11'h0E8, 64'd0, 64'd0, 5'd1, 1'b1);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_wb_en", 64'(out_wb_en), 64'd0);
        chk("rst_out_misalign", 64'(out_misalign), 64'd0);
        chk("rst_mem_read_en", 64'(mem_read_en), 64'd0);
        chk("rst_mem_write_en", 64'(mem_write_en), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Preload word 29 with a full-width store.
        issue(STORE, D, 1'b0, 11'h0E8, 64'd0, 64'hFF00_0000_0000_0000, 5'd1, 1'b1);
        chk("stD_acc_ready", 64'(acc_rdy), 64'd1);
        chk("stD_acc_wr", 64'(acc_wr), 64'd1);
        chk("stD_acc_rd", 64'(acc_rd), 64'd0);
        chk("stD_out_valid", 64'(out_valid), 64'd1);
        chk("stD_out_wb_en", 64'(out_wb_en), 64'd0);
        chk("stD_mem29", mem[29], 64'hFF00_0000_0000_0000);

        issue(LOAD, D, 1'b0, 11'h0E8, 64'd0, 64'd0, 5'd3, 1'b1);
        chk("ldD_acc_rd", 64'(acc_rd), 64'd1);
        chk("ldD_data", out_data, 64'hFF00_0000_0000_0000);
        chk("ldD_wb_en", 64'(out_wb_en), 64'd1);
        chk("ldD_rd", 64'(out_rd), 64'd3);

        issue(LOAD, B, 1'b1, 11'h0EF, 64'd0, 64'd0, 5'd4, 1'b1);
        chk("ldB_signed", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(LOAD, B, 1'b0, 11'h0EF, 64'd0, 64'd0, 5'd4, 1'b1);
        chk("ldB_unsigned", out_data, 64'h0000_0000_0000_00FF);

        wc0 = wr_count;
        issue(STORE, H, 1'b0, 11'h102, 64'd0, 64'h1234_5678_9ABC_BEEF, 5'd5, 1'b1);
        chk("stH_acc_rd", 64'(acc_rd), 64'd1);
        chk("stH_acc_wr", 64'(acc_wr), 64'd0);
        chk("stH_rmw_in_ready", 64'(in_ready), 64'd0);
        chk("stH_rmw_out_valid", 64'(out_valid), 64'd0);
        chk("stH_rmw_wr", 64'(mem_write_en), 64'd1);
        chk("stH_rmw_addr", 64'(mem_address), 64'd32);
        chk("stH_rmw_wdata", mem_data_in, 64'h0000_0000_BEEF_0000);
        @(posedge clk);
        #1;
        chk("stH_out_valid", 64'(out_valid), 64'd1);
        chk("stH_out_wb_en", 64'(out_wb_en), 64'd0);
        chk("stH_out_rd", 64'(out_rd), 64'd5);
        chk("stH_in_ready", 64'(in_ready), 64'd1);
        chk("stH_write_pulses", 64'(wr_count - wc0), 64'd1);
        chk("stH_mem32", mem[32], 64'h0000_0000_BEEF_0000);

        issue(LOAD, D, 1'b0, 11'h100, 64'd0, 64'd0, 5'd6, 1'b1);
        chk("ldD_after_stH", out_data, 64'h0000_0000_BEEF_0000);
        issue(LOAD, H, 1'b1, 11'h102, 64'd0, 64'd0, 5'd6, 1'b1);
        chk("ldH_signed", out_data, 64'hFFFF_FFFF_FFFF_BEEF);
        issue(LOAD, W, 1'b0, 11'h100, 64'd0, 64'd0, 5'd6, 1'b1);
        chk("ldW_unsigned", out_data, 64'h0000_0000_BEEF_0000);

        wc0 = wr_count;
        issue(STORE, W, 1'b0, 11'h105, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA, 5'd7, 1'b1);
        chk("misW_acc_rd", 64'(acc_rd), 64'd0);
        chk("misW_acc_wr", 64'(acc_wr), 64'd0);
        chk("misW_out_valid", 64'(out_valid), 64'd1);
        chk("misW_misalign", 64'(out_misalign), 64'd1);
        chk("misW_wb_en", 64'(out_wb_en), 64'd0);
        chk("misW_data", out_data, 64'd0);
        @(posedge clk);
        #1;
        chk("misW_no_write", 64'(wr_count - wc0), 64'd0);
        chk("misW_mem32", mem[32], 64'h0000_0000_BEEF_0000);

        issue(LOAD, H, 1'b0, 11'h101, 64'd0, 64'd0, 5'd8, 1'b1);
        chk("misH_acc_rd", 64'(acc_rd), 64'd0);
        chk("misH_misalign", 64'(out_misalign), 64'd1);
        chk("misH_wb_en", 64'(out_wb_en), 64'd0);

        issue(STORE, D, 1'b0, 11'h108, 64'd0, 64'h0000_0000_0000_1234, 5'd8, 1'b0);
        issue(LOAD, D, 1'b0, 11'h108, 64'd0, 64'd0, 5'd9, 1'b1);
        chk("b2b_acc_ready", 64'(acc_rdy), 64'd1);
        chk("b2b_data", out_data, 64'h0000_0000_0000_1234);
        chk("b2b_misalign", 64'(out_misalign), 64'd0);

        @(negedge clk);
        out_ready = 1'b0;
        set_in(PASS, D, 1'b0, 11'h000, 64'h0000_0000_0000_DEAD, 64'd0, 5'd10, 1'b1);
        #1;
        chk("hold_in_ready_now", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, 64'h0000_0000_0000_1234);
            chk("hold_rd", 64'(out_rd), 64'd9);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pass_data", out_data, 64'h0000_0000_0000_DEAD);
        chk("pass_wb_en", 64'(out_wb_en), 64'd1);
        chk("pass_rd", 64'(out_rd), 64'd10);

        issue(RSVD, B, 1'b0, 11'h101, 64'h0000_0000_0000_0055, 64'd0, 5'd11, 1'b0);
        chk("rsvd_acc_rd", 64'(acc_rd), 64'd0);
        chk("rsvd_acc_wr", 64'(acc_wr), 64'd0);
        chk("rsvd_data", out_data, 64'h0000_0000_0000_0055);
        chk("rsvd_wb_en", 64'(out_wb_en), 64'd0);
        chk("rsvd_misalign", 64'(out_misalign), 64'd0);
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("idle_rd_en", 64'(mem_read_en), 64'd0);
        chk("idle_wr_en", 64'(mem_write_en), 64'd0);

        issue(STORE, B, 1'b0, 11'h110, 64'd0, 64'h0000_0000_0000_00AB, 5'd12, 1'b1);
        chk("rstrmw_in_rmw", 64'(in_ready), 64'd0);
        wc0 = wr_count;
        rst_n = 1'b0;
        #1;
        chk("rstrmw_wr_en", 64'(mem_write_en), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstrmw_no_write", 64'(wr_count - wc0), 64'd0);
        chk("rstrmw_mem34", mem[34], 64'd0);
        chk("rstrmw_out_valid", 64'(out_valid), 64'd0);
        chk("rstrmw_idle", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage of the aurora 64-bit core. Sits between the EX/MEM register and the writeback stage.
- Drives the single-port 256 x 64-bit data memory: 8-bit word address, synchronous write, combinational read gated by read_en.
- Supports byte/half/word/double loads and stores with sign/zero extension and alignment checking.
- Sub-doubleword stores are done as a 2-cycle read-modify-write. Non-memory ops pass through.

Parameters:
- DATA_W, 64, datapath and memory word width.
- MEM_AW, 8, memory word-address width.
- BYTE_AW, 11, byte address width (MEM_AW + 3).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX result valid
- in_ready  out  1  stage can accept
- in_op  in  2  0=PASS, 1=LOAD, 2=STORE, 3=reserved (treated as PASS)
- in_size  in  2  0=B, 1=H, 2=W, 3=D
- in_signed  in  1  sign-extend load result
- in_addr  in  BYTE_AW  byte address (ALU result low bits)
- in_alu_result  in  DATA_W  pass-through value for PASS
- in_wdata  in  DATA_W  store data, right-aligned
- in_rd  in  RD_W  destination register
- in_wb_en  in  1  writeback requested
- out_valid  out  1  result valid to WB
- out_ready  in  1  WB accepts
- out_data  out  DATA_W  load data or pass-through
- out_rd  out  RD_W  destination register
- out_wb_en  out  1  register-file write enable
- out_misalign  out  1  access misaligned, suppressed
- mem_address  out  MEM_AW  to data memory
- mem_data_in  out  DATA_W  to data memory
- mem_write_en  out  1  to data memory
- mem_read_en  out  1  to data memory
- mem_data_out  in  DATA_W  from data memory

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
  - State goes to IDLE; out_valid, out_wb_en, out_misalign = 0; out_data = 0; out_rd = 0.
  - Memory controls are forced 0 while rst_n = 0.
  - Reset during RMW_WRITE aborts the write; the memory word is left unmodified.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - Output holds stable while out_valid && !out_ready.
- Addressing:
  - mem_address = in_addr[10:3] in IDLE; latched addr[10:3] in RMW_WRITE.
  - Byte offset = addr[2:0].
  - Aligned means offset is a multiple of the access size in bytes.
- FSM states: IDLE, RMW_WRITE.
- IDLE, accepted LOAD, aligned:
  - mem_read_en = 1 combinationally.
  - Lane is extracted as mem_data_out >> (offset*8), masked to the access size, then sign- or zero-extended.
  - Result is registered into out_data. Latency is 1 cycle.
- IDLE, accepted STORE size D, aligned:
  - mem_write_en = 1 and mem_data_in = in_wdata in the accept cycle.
  - out_wb_en = 0. Latency is 1 cycle.
- IDLE, accepted STORE size B/H/W, aligned:
  - mem_read_en = 1 in the accept cycle.
  - Capture the merged word: old word with the lane replaced by in_wdata[size-1:0] << (offset*8).
  - Go to RMW_WRITE. in_ready = 0 there.
- RMW_WRITE:
  - mem_write_en = 1, mem_data_in = merged word.
  - Next state is IDLE. out_valid rises at the end of this cycle, so a partial store has 2-cycle latency.
- Misaligned LOAD/STORE:
  - No memory access.
  - out_misalign = 1, out_wb_en = 0, out_data = 0. Latency is 1 cycle.
- PASS: out_data = in_alu_result, out_wb_en = in_wb_en. No memory access.
- LOAD out_wb_en = in_wb_en.
- Back-to-back accesses:
  - A store followed by a load to the same word returns the new data. The write commits at the posedge; the next-cycle read is combinational.
  - No forwarding logic is needed.
- Memory controls are never asserted when no transfer is occurring and state == IDLE.

Decomposition:
- Package aurora_mem_pkg holds:
  - op_e (PASS/LOAD/STORE)
  - size_e (B/H/W/D)
  - state_e (IDLE/RMW_WRITE)
  - DATA_W/MEM_AW/BYTE_AW constants
  - function size_bytes(size_e)
- One combinational sub-module, mem_lane_align, holds:
  - load extract and extend (data, offset, size, signed) -> result
  - store merge (old, wdata, offset, size) -> merged
  - misalign detect

Test Plan:
- LOAD D at word 29 (addr 0xE8), unsigned -> out_data=0xFF00000000000000 after 1 cycle, out_wb_en=1.
- LOAD B signed at addr 0xEF (word 29 byte 7) -> out_data=0xFFFFFFFFFFFFFFFF. The same access unsigned -> 0x00000000000000FF.
- STORE H 0xBEEF at addr 0x102 (word 32 offset 2), then LOAD D at 0x100 -> 0x00000000BEEF0000.
  - in_ready is low for one cycle during RMW_WRITE.
  - Only one mem_write_en pulse occurs.
- STORE W at addr 0x105 -> out_misalign=1, mem_write_en never asserted, word 32 unchanged.
- Back-to-back: STORE D 0x1234 at 0x108, then LOAD D at 0x108 on the next cycle -> 0x1234. Hold out_ready=0 for 3 cycles mid-stream -> outputs stable, in_ready=0.
- Assert rst_n=0 during RMW_WRITE of STORE B to 0x110 -> no write, word 34 still 0, out_valid=0, state IDLE after release.
